// File: rtl/rv_pkg.sv
// Shared architectural constants for the register-file writeback path.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = {AW{1'b0}};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the
// rotating pointer, which advances past each winner.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;
  logic          found;

  // Pick the first requester at or after ptr, wrapping modulo N.
  always_comb begin
    gnt   = {N{1'b0}};
    idx   = {PW{1'b0}};
    found = 1'b0;
    cand  = {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end else begin
        cand = cand;
      end
      if (!found && req[cand[PW-1:0]]) begin
        gnt[cand[PW-1:0]] = 1'b1;
        idx               = cand[PW-1:0];
        found             = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Move the search start just past the winner; hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= {PW{1'b0}};
    end else if (found) begin
      ptr <= (idx == PW'(N - 1)) ? {PW{1'b0}} : idx + PW'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port with a busy
// scoreboard that lets decode stall on outstanding destination writes.
module regfile_wb_arbiter #(
  parameter  int NUM_REQ = 3,
  parameter  int XLEN    = rv_pkg::XLEN,
  parameter  int NREGS   = rv_pkg::NREGS,
  localparam int AW      = $clog2(NREGS),
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  input  logic [AW-1:0]           a0,
  input  logic [AW-1:0]           a1,
  output logic                    busy0,
  output logic                    busy1,
  output logic [AW-1:0]           wr,
  output logic                    write_enable,
  output logic [XLEN-1:0]         din
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gidx;
  logic [AW-1:0]      sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [AW-1:0]      wr_q;
  logic [XLEN-1:0]    din_q;
  logic               we_q;
  logic [NREGS-1:0]   sb;
  logic [NREGS-1:0]   sb_set;
  logic [NREGS-1:0]   sb_clr;

  // No grants while in reset, so requesters cannot complete a handshake.
  assign arb_req = req_valid & ~{NUM_REQ{rst}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready = gnt;
  assign sel_rd    = req_rd[gidx*AW +: AW];
  assign sel_data  = req_data[gidx*XLEN +: XLEN];

  // The strobe is masked by reset so a write pending at reset never commits.
  assign wr           = wr_q;
  assign din          = din_q;
  assign write_enable = we_q & ~rst;

  // Register the winning write; x0 consumes the slot but never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= {AW{1'b0}};
      din_q <= {XLEN{1'b0}};
      we_q  <= 1'b0;
    end else if (|gnt) begin
      wr_q  <= sel_rd;
      din_q <= sel_data;
      we_q  <= (sel_rd != {AW{1'b0}});
    end else begin
      wr_q  <= wr_q;
      din_q <= din_q;
      we_q  <= 1'b0;
    end
  end

  // Decode the scoreboard set (new producer) and clear (commit) vectors.
  always_comb begin
    sb_set = {NREGS{1'b0}};
    sb_clr = {NREGS{1'b0}};
    if (issue_valid && (issue_rd != {AW{1'b0}})) begin
      sb_set[issue_rd] = 1'b1;
    end else begin
      sb_set = {NREGS{1'b0}};
    end
    if (write_enable) begin
      sb_clr[wr_q] = 1'b1;
    end else begin
      sb_clr = {NREGS{1'b0}};
    end
  end

  // Update scoreboard; set is applied after clear so a newer producer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= {NREGS{1'b0}};
    end else begin
      sb <= ((sb & ~sb_clr) | sb_set) & {{(NREGS-1){1'b1}}, 1'b0};
    end
  end

  assign busy0 = sb[a0];
  assign busy1 = sb[a1];

endmodule
